usb_data_fifo: RTL and testbench

Parametrised byte FIFO between the USB packet engine and the AHB-Lite slave. It replaces the fixed 64-byte data buffer: configurable depth, 1/2/4-byte reads for word-wide bus access, and full/empty status. Overflow and underflow are rejected and reported instead of silently wiping the buffer. Bytes enter one per cycle from the packet side and leave oldest-first on the bus side.

---
 rtl/usb_data_fifo.sv | 96 +++++++++
 tb/tb_usb_data_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/usb_data_fifo.sv
// Byte FIFO between the USB packet engine (1 byte/cycle in) and the AHB-Lite slave (1/2/4 bytes out).
// Latency: a byte pushed at edge t is visible on rd_data/occupancy after t. No stall; rejected ops raise overflow/underflow.
// Build option: define USB_FIFO_ERRFLAG_EN for sticky overflow/underflow registers; otherwise both flags are tied to 0.
module usb_data_fifo #(
    parameter int DEPTH = 64,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    input  logic [1:0]       rd_size,
    input  logic             flush,
    input  logic             clear,
    output logic [31:0]      rd_data,
    output logic [OCC_W-1:0] occupancy,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [OCC_W-1:0] wr_ptr;
    logic [OCC_W-1:0] rd_ptr;
    logic [OCC_W-1:0] rd_n;
    logic             drop;
    logic             wr_acc;
    logic             rd_acc;

    assign drop      = flush | clear;
    assign occupancy = wr_ptr - rd_ptr;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy == OCC_W'(DEPTH));

    always_comb begin
        rd_n = OCC_W'(4);
        case (rd_size)
            2'd0:    rd_n = OCC_W'(1);
            2'd1:    rd_n = OCC_W'(2);
            default: rd_n = OCC_W'(4);
        endcase
    end

    // Both acceptance tests use pre-edge occupancy, so a same-cycle pop never makes room for a push.
    assign wr_acc = wr_en & ~full & ~drop;
    assign rd_acc = rd_en & (occupancy >= rd_n) & ~drop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (drop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + OCC_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + rd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Bytes beyond the current occupancy read as zero, so stale storage never leaks onto the bus.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (OCC_W'(k) < occupancy)
                rd_data[8*k +: 8] = mem[rd_ptr[AW-1:0] + AW'(k)];
        end
    end

`ifdef USB_FIFO_ERRFLAG_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (drop) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)   overflow  <= 1'b1;
            if (rd_en && !rd_acc) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_usb_data_fifo.sv
// Randomized and directed checks of usb_data_fifo against a queue-based byte model.
module tb_usb_data_fifo;

    localparam int DEPTH = 16;
    localparam int OCC_W = $clog2(DEPTH) + 1;
`ifdef USB_FIFO_ERRFLAG_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             n_rst;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             rd_en;
    logic [1:0]       rd_size;
    logic             flush;
    logic             clear;
    logic [31:0]      rd_data;
    logic [OCC_W-1:0] occupancy;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    usb_data_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_size(rd_size), .flush(flush), .clear(clear),
        .rd_data(rd_data), .occupancy(occupancy), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a byte queue (front = oldest), flags as plain bits.
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_udf;
    int         checks = 0;
    int         errors = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [31:0] exp_rd;
        exp_rd = '0;
        for (int k = 0; k < 4; k++)
            if (k < q.size()) exp_rd[8*k +: 8] = q[k];
        chk_val({tag, ".occ"},   32'(occupancy), 32'(q.size()));
        chk_val({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
        chk_val({tag, ".full"},  32'(full),      32'(q.size() == DEPTH));
        chk_val({tag, ".rdata"}, rd_data,        exp_rd);
        chk_val({tag, ".ovf"},   32'(overflow),  32'(FLAGS_EN & m_ovf));
        chk_val({tag, ".udf"},   32'(underflow), 32'(FLAGS_EN & m_udf));
    endtask

    task automatic model_edge(input bit w, input logic [7:0] d, input bit r,
                              input logic [1:0] sz, input bit fl, input bit cl);
        int n;
        bit wacc;
        bit racc;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (fl || cl) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            wacc = w && (q.size() < DEPTH);
            racc = r && (q.size() >= n);
            if (racc) for (int i = 0; i < n; i++) void'(q.pop_front());
            if (wacc) q.push_back(d);
            if (w && !wacc) m_ovf = 1;
            if (r && !racc) m_udf = 1;
        end
    endtask

    // Called at a negedge: drive, clock one edge, update model, check at next negedge.
    task automatic step(input string tag, input bit w, input logic [7:0] d, input bit r,
                        input logic [1:0] sz, input bit fl, input bit cl);
        wr_en = w; wr_data = d; rd_en = r; rd_size = sz; flush = fl; clear = cl;
        @(posedge clk);
        model_edge(w, d, r, sz, fl, cl);
        @(negedge clk);
        wr_en = 0; rd_en = 0; flush = 0; clear = 0;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 0; wr_en = 0; wr_data = 0; rd_en = 0; rd_size = 0; flush = 0; clear = 0;
        repeat (2) @(negedge clk);
        check_state("reset");
        chk_val("reset.rdata0", rd_data, 32'h0);
        n_rst = 1;

        // Four pushes then one 4-byte pop
        step("p11", 1, 8'h11, 0, 0, 0, 0);
        step("p22", 1, 8'h22, 0, 0, 0, 0);
        step("p33", 1, 8'h33, 0, 0, 0, 0);
        step("p44", 1, 8'h44, 0, 0, 0, 0);
        chk_val("word4.rdata", rd_data, 32'h44332211);
        chk_val("word4.occ", 32'(occupancy), 32'd4);
        step("pop4", 0, 0, 1, 2'd2, 0, 0);
        chk_val("pop4.empty", 32'(empty), 32'd1);
        chk_val("pop4.rdata", rd_data, 32'h0);

        // Fill, overflow, then drain in order
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 8'(i), 0, 0, 0, 0);
        step("ovf", 1, 8'hAA, 0, 0, 0, 0);
        chk_val("ovf.full", 32'(full), 32'd1);
        chk_val("ovf.flag", 32'(overflow), 32'(FLAGS_EN));
        for (int i = 0; i < DEPTH; i++) begin
            chk_val("drain.byte", 32'(rd_data[7:0]), 32'(i));
            step("drain", 0, 0, 1, 2'd0, 0, 0);
        end
        chk_val("drain.ovf_hold", 32'(overflow), 32'(FLAGS_EN));
        step("clr", 0, 0, 0, 0, 0, 1);

        // Underflow at occupancy 3 with a 4-byte request (rd_size 3)
        for (int i = 0; i < 3; i++) step("u3", 1, 8'(8'hC0 + i), 0, 0, 0, 0);
        step("udf", 0, 0, 1, 2'd3, 0, 0);
        chk_val("udf.occ", 32'(occupancy), 32'd3);
        chk_val("udf.flag", 32'(underflow), 32'(FLAGS_EN));
        chk_val("udf.top", 32'(rd_data[31:24]), 32'h0);
        step("fl1", 0, 0, 0, 0, 1, 0);

        // Occupancy 5, simultaneous push and 4-byte pop
        for (int i = 0; i < 5; i++) step("o5", 1, 8'(i + 1), 0, 0, 0, 0);
        step("rw", 1, 8'h5A, 1, 2'd2, 0, 0);
        chk_val("rw.occ", 32'(occupancy), 32'd2);
        chk_val("rw.byte1", 32'(rd_data[15:8]), 32'h5A);

        // Steady-state wrap: one in, one out per cycle
        step("pre", 1, 8'h00, 0, 0, 0, 0);
        for (int i = 1; i <= 3*DEPTH; i++) step("wrap", 1, 8'(i), 1, 2'd0, 0, 0);
        chk_val("wrap.occ", 32'(occupancy), 32'd3);

        // Flush beats concurrent read and write
        step("flw", 1, 8'hEE, 1, 2'd0, 1, 0);
        chk_val("flw.occ", 32'(occupancy), 32'd0);

        // Asynchronous reset in the middle of a write burst
        step("rw1", 1, 8'h77, 0, 0, 0, 0);
        step("rw2", 1, 8'h78, 0, 0, 0, 0);
        wr_en = 1; wr_data = 8'h79;
        #2 n_rst = 0;
        #1;
        q.delete(); m_ovf = 0; m_udf = 0;
        check_state("arst");
        @(negedge clk);
        wr_en = 0;
        n_rst = 1;
        step("post_rst", 1, 8'h9C, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit w, r, fl, cl;
            w  = ($urandom_range(0, 99) < 60);
            r  = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 199) == 0);
            cl = ($urandom_range(0, 199) == 0);
            step("rand", w, 8'($urandom), r, 2'($urandom), fl, cl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
